// File: rtl/approx_or_adder_seq.sv
// Multi-cycle lower-part-OR approximate adder with a parallel exact reference,
// CHUNK bits per cycle, valid/ready on both sides and a saturating error counter.
module approx_or_adder_seq #(
    parameter  int WIDTH = 16,
    parameter  int CHUNK = 4,
    parameter  int MAX_K = 8,
    parameter  int CNT_W = 16,
    localparam int K_W   = $clog2(MAX_K + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [K_W-1:0]   k,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             err_flag,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             cnt_clr
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // r_a / r_b shift right one chunk per ADD cycle; the approximate and exact
    // result chunks are shifted in at the top, so they end up holding the sums.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_top;
    logic             r_ap_c;
    logic             r_ex_c;
    logic [IDX_W-1:0] r_idx;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    logic [K_W-1:0]   w_keff;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_top;
    logic [CHUNK-1:0] w_ap_chunk;
    logic [CHUNK-1:0] w_ex_chunk;
    logic             w_ap_cout;
    logic             w_ex_cout;
    logic [WIDTH-1:0] w_ap_next;
    logic [WIDTH-1:0] w_ex_next;
    logic             w_last;
    logic             w_deliver;

    assign w_keff = (k > K_W'(MAX_K)) ? K_W'(MAX_K) : k;

    // w_mask marks approximate bit positions; w_top marks bit K-1, whose AND
    // becomes the carry into the exact part.
    always_comb begin
        w_mask = '0;
        w_top  = '0;
        for (int p = 0; p < WIDTH; p++) begin
            w_mask[p] = (p < int'(w_keff));
            w_top[p]  = (p == int'(w_keff) - 1);
        end
    end

    // NOTE: the carry chain is a combinational ripple inside one process, so
    // the running carries use blocking assignments; registers elsewhere use <=.
    always_comb begin
        logic c_ap;
        logic c_ex;
        logic ab;
        logic bb;
        c_ap       = r_ap_c;
        c_ex       = r_ex_c;
        w_ap_chunk = '0;
        w_ex_chunk = '0;
        for (int j = 0; j < CHUNK; j++) begin
            ab = r_a[j];
            bb = r_b[j];
            if (r_mask[j]) begin
                w_ap_chunk[j] = ab | bb;
                c_ap          = r_top[j] & ab & bb;
            end else begin
                w_ap_chunk[j] = ab ^ bb ^ c_ap;
                c_ap          = (ab & bb) | (c_ap & (ab ^ bb));
            end
            w_ex_chunk[j] = ab ^ bb ^ c_ex;
            c_ex          = (ab & bb) | (c_ex & (ab ^ bb));
        end
        w_ap_cout = c_ap;
        w_ex_cout = c_ex;
    end

    assign w_ap_next = WIDTH'({w_ap_chunk, r_a} >> CHUNK);
    assign w_ex_next = WIDTH'({w_ex_chunk, r_b} >> CHUNK);
    assign w_last    = (r_idx == IDX_W'(NCHUNK - 1));
    assign w_deliver = (r_state == S_DONE) && out_ready;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_nxt = S_ADD;
            S_ADD:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE:  in_ready  = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_mask <= '0;
            r_top  <= '0;
            r_ap_c <= 1'b0;
            r_ex_c <= 1'b0;
            r_idx  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a    <= a;
                        r_b    <= b;
                        r_mask <= w_mask;
                        r_top  <= w_top;
                        r_ap_c <= (w_keff == '0) ? cin : 1'b0;
                        r_ex_c <= cin;
                        r_idx  <= '0;
                    end
                end
                S_ADD: begin
                    r_a    <= w_ap_next;
                    r_b    <= w_ex_next;
                    r_mask <= r_mask >> CHUNK;
                    r_top  <= r_top >> CHUNK;
                    r_ap_c <= w_ap_cout;
                    r_ex_c <= w_ex_cout;
                    if (w_last) begin
                        r_idx  <= '0;
                        r_sum  <= w_ap_next;
                        r_cout <= w_ap_cout;
                        r_err  <= ({w_ap_cout, w_ap_next} != {w_ex_cout, w_ex_next});
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Clear wins over a coincident increment; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst)                                   r_cnt <= '0;
        else if (cnt_clr)                          r_cnt <= '0;
        else if (w_deliver && r_err && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
    end

    assign sum      = r_sum;
    assign cout     = r_cout;
    assign err_flag = r_err;
    assign err_cnt  = r_cnt;

endmodule

// File: tb/tb_approx_or_adder_seq.sv
// Directed bench for approx_or_adder_seq (WIDTH=16, CHUNK=4, MAX_K=8, CNT_W=3).
module tb_approx_or_adder_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [3:0]  k;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        err_flag;
    logic [2:0]  err_cnt;
    logic        cnt_clr;

    int total = 0;
    int bad   = 0;

    approx_or_adder_seq #(
        .WIDTH(16),
        .CHUNK(4),
        .MAX_K(8),
        .CNT_W(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .k        (k),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .err_flag (err_flag),
        .err_cnt  (err_cnt),
        .cnt_clr  (cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                          input logic [3:0] tk);
        a        = ta;
        b        = tb_v;
        cin      = tc;
        k        = tk;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Cycles after the accept edge until out_valid is seen; 99 on timeout.
    task automatic wait_out(output int lat);
        lat = 99;
        for (int c = 1; c <= 20; c++) begin
            if (out_valid) begin
                lat = c - 1;
                break;
            end
            tick();
        end
    endtask

    task automatic txn(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                       input logic tc, input logic [3:0] tk, input logic [15:0] esum,
                       input logic ecout, input logic eerr, input logic clr,
                       input logic [2:0] ecnt);
        int lat;
        accept(ta, tb_v, tc, tk);
        tick();
        wait_out(lat);
        check({tag, "_lat"}, lat + 1, 4);
        check({tag, "_sum"}, sum, esum);
        check({tag, "_cout"}, cout, ecout);
        check({tag, "_err"}, err_flag, eerr);
        out_ready = 1'b1;
        cnt_clr   = clr;
        tick();
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        check({tag, "_cnt"}, err_cnt, ecnt);
        check({tag, "_idle"}, {in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        int lat;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        k         = '0;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_err", err_flag, 0);
        check("rst_cnt", err_cnt, 0);

        // Exact path with full carry ripple; latency counted from the accept edge.
        accept(16'hFFFF, 16'h0001, 1'b0, 4'd0);
        check("t1_busy", in_ready, 0);
        wait_out(lat);
        check("t1_lat", lat, 4);
        check("t1_sum", sum, 16'h0000);
        check("t1_cout", cout, 1);
        check("t1_err", err_flag, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t1_cnt", err_cnt, 0);
        check("t1_idle", {in_ready, out_valid}, 2'b10);
        check("t1_retain", sum, 16'h0000);

        txn("t2", 16'h000F, 16'h0001, 1'b0, 4'd4, 16'h000F, 1'b0, 1'b1, 1'b0, 3'd1);
        txn("t3", 16'h0008, 16'h0008, 1'b1, 4'd4, 16'h0018, 1'b0, 1'b1, 1'b0, 3'd2);
        txn("t4", 16'h00FF, 16'h0001, 1'b0, 4'd15, 16'h00FF, 1'b0, 1'b1, 1'b0, 3'd3);
        txn("t6", 16'h1234, 16'h0F0F, 1'b1, 4'd0, 16'h2144, 1'b0, 1'b0, 1'b0, 3'd3);
        txn("t7", 16'h8000, 16'h8000, 1'b0, 4'd8, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd3);

        // K=6 splits chunk 1; then hold the result with out_ready low.
        accept(16'h1234, 16'h0F0F, 1'b0, 4'd6);
        wait_out(lat);
        check("t5_lat", lat, 4);
        check("t5_sum", sum, 16'h213F);
        check("t5_cout", cout, 0);
        check("t5_err", err_flag, 1);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a        = 16'hA5A5;
            b        = 16'h5A5A;
            k        = 4'd0;
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_ready", in_ready, 0);
            check("hold_sum", sum, 16'h213F);
            check("hold_flags", {cout, err_flag}, 2'b01);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t5_cnt", err_cnt, 4);
        check("t5_idle", {in_ready, out_valid}, 2'b10);

        // Reset in the second ADD cycle abandons the transaction.
        accept(16'h000F, 16'h0001, 1'b0, 4'd4);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_sum", sum, 0);
        check("mid_rst_flags", {cout, err_flag}, 2'b00);
        check("mid_rst_cnt", err_cnt, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("mid_rst_no_result", out_valid, 0);
        end

        // Saturate the 3-bit counter, then clear it on an erroneous handshake.
        for (int i = 1; i <= 8; i++) begin
            txn("sat", 16'h000F, 16'h0001, 1'b0, 4'd4, 16'h000F, 1'b0, 1'b1, 1'b0,
                (i > 7) ? 3'd7 : 3'(i));
        end
        txn("clr", 16'h000F, 16'h0001, 1'b0, 4'd4, 16'h000F, 1'b0, 1'b1, 1'b1, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
